// File: rtl/outputs_workload_pkg.sv
// Shared types and constants for the handshaked workload distributor.
//
// Contents:
//   mode_e         - per-descriptor mode (replicate or split)
//   state_e        - distributor control state (idle or busy)
//   stats_width_gp - width of the optional statistics counters
//   rot_width()    - width of the remainder rotation pointer for n outputs
package outputs_workload_pkg;

  typedef enum logic {
    e_replicate = 1'b0,
    e_split     = 1'b1
  } mode_e;

  typedef enum logic {
    e_idle = 1'b0,
    e_busy = 1'b1
  } state_e;

  localparam int unsigned stats_width_gp = 32;

  // A single output still needs a one-bit pointer so the port is never zero width.
  function automatic int unsigned rot_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/outputs_workload_split.sv
// Combinational share calculator for one workload descriptor.
//
// Ports:
//   size_i     - descriptor size (unsigned)
//   mode_i     - e_replicate: every output gets size_i; e_split: size_i is divided
//   rot_i      - current remainder start pointer
//   share_o    - per-output share
//   nonzero_o  - outputs that must be emitted (all ones for replicate)
//   rot_next_o - remainder start pointer to use for the following descriptor
//
// In split mode q = size / n and r = size % n; the r outputs starting at rot_i
// (wrapping) get q+1 and the rest get q, so the shares always sum to size_i.
module outputs_workload_split
  import outputs_workload_pkg::*;
#(
  parameter int unsigned size_width_p       = 8,
  parameter int unsigned num_out_p          = 4,
  parameter int unsigned rotate_remainder_p = 1,
  parameter int unsigned rot_width_p        = rot_width(num_out_p)
) (
  input  logic [size_width_p-1:0]                 size_i,
  input  mode_e                                   mode_i,
  input  logic [rot_width_p-1:0]                  rot_i,
  output logic [num_out_p-1:0][size_width_p-1:0]  share_o,
  output logic [num_out_p-1:0]                    nonzero_o,
  output logic [rot_width_p-1:0]                  rot_next_o
);

  // Arithmetic is done at least 32 bits wide so num_out_p never truncates.
  localparam int unsigned ext_w_lp = (size_width_p > 32) ? size_width_p : 32;

  logic [ext_w_lp-1:0] n_ext, size_ext, rot_ext;
  logic [ext_w_lp-1:0] q, r, idx, rot_sum;

  assign n_ext    = ext_w_lp'(num_out_p);
  assign size_ext = ext_w_lp'(size_i);
  assign rot_ext  = ext_w_lp'(rot_i);
  assign q        = size_ext / n_ext;
  assign r        = size_ext % n_ext;
  assign rot_sum  = rot_ext + r;

  always_comb begin
    share_o   = '0;
    nonzero_o = '0;
    idx       = '0;
    for (int unsigned i = 0; i < num_out_p; i++) begin
      // Distance of output i from the remainder start, modulo num_out_p.
      if (ext_w_lp'(i) >= rot_ext) begin
        idx = ext_w_lp'(i) - rot_ext;
      end else begin
        idx = ext_w_lp'(i) + n_ext - rot_ext;
      end
      if (mode_i == e_replicate) begin
        share_o[i]   = size_i;
        nonzero_o[i] = 1'b1;
      end else begin
        share_o[i]   = (idx < r) ? size_width_p'(q + 1'b1) : size_width_p'(q);
        nonzero_o[i] = (share_o[i] != '0);
      end
    end
  end

  always_comb begin
    rot_next_o = rot_i;
    if (mode_i == e_split) begin
      if (rotate_remainder_p == 0) begin
        rot_next_o = '0;
      end else if (rot_sum >= n_ext) begin
        rot_next_o = rot_width_p'(rot_sum - n_ext);
      end else begin
        rot_next_o = rot_width_p'(rot_sum);
      end
    end
  end

endmodule

// File: rtl/outputs_workload_distribute.sv
// Handshaked workload distributor: accepts one {id, size} descriptor and issues
// per-output {id, share} descriptors to num_out_p consumers with independent
// valid/ready. Split mode divides size with a rotating remainder start;
// replicate mode sends the full size to every output.
//
// Ports:
//   clk_i        - clock
//   reset_n_i    - synchronous active-low reset
//   v_i          - input descriptor valid
//   data_i       - {id, size}
//   mode_i       - 0: replicate, 1: split (sampled with data_i)
//   ready_and_o  - input ready; accepted when v_i & ready_and_o
//   v_o          - per-output valid
//   data_o       - per-output {id, share}, stable while the output is valid
//   ready_and_i  - per-output ready
//   busy_o       - a descriptor is in flight
//
// Optional build macro OUTPUTS_WORKLOAD_STATS_EN adds:
//   stats_o      - per-output saturating sum of shares handed off
//   desc_count_o - saturating count of accepted descriptors
module outputs_workload_distribute
  import outputs_workload_pkg::*;
#(
  parameter int unsigned id_width_p         = 8,
  parameter int unsigned size_width_p       = 8,
  parameter int unsigned num_out_p          = 4,
  parameter int unsigned rotate_remainder_p = 1,
  parameter int unsigned width_p            = id_width_p + size_width_p
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 v_i,
  input  logic [width_p-1:0]                   data_i,
  input  logic                                 mode_i,
  output logic                                 ready_and_o,
  output logic [num_out_p-1:0]                 v_o,
  output logic [num_out_p-1:0][width_p-1:0]    data_o,
  input  logic [num_out_p-1:0]                 ready_and_i,
`ifdef OUTPUTS_WORKLOAD_STATS_EN
  output logic [num_out_p-1:0][stats_width_gp-1:0] stats_o,
  output logic [stats_width_gp-1:0]                desc_count_o,
`endif
  output logic                                 busy_o
);

  localparam int unsigned rot_width_lp = rot_width(num_out_p);

  state_e                                 state_q, state_d;
  logic [num_out_p-1:0]                   pend_q, pend_d;
  logic [rot_width_lp-1:0]                rot_q, rot_d;
  logic [num_out_p-1:0][width_p-1:0]      data_q, data_d;

  logic [id_width_p-1:0]                  id_in;
  logic [size_width_p-1:0]                size_in;
  logic [num_out_p-1:0][size_width_p-1:0] share;
  logic [num_out_p-1:0]                   nonzero;
  logic [rot_width_lp-1:0]                rot_next;
  logic                                   accept;
  logic [num_out_p-1:0]                   out_hs;

  assign id_in   = data_i[width_p-1 -: id_width_p];
  assign size_in = data_i[size_width_p-1:0];
  assign accept  = v_i & ready_and_o;
  assign out_hs  = v_o & ready_and_i;

  outputs_workload_split #(
    .size_width_p       (size_width_p),
    .num_out_p          (num_out_p),
    .rotate_remainder_p (rotate_remainder_p),
    .rot_width_p        (rot_width_lp)
  ) u_split (
    .size_i     (size_in),
    .mode_i     (mode_e'(mode_i)),
    .rot_i      (rot_q),
    .share_o    (share),
    .nonzero_o  (nonzero),
    .rot_next_o (rot_next)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An all-zero mask (empty split) still spends one busy cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle: if (accept) state_d = e_busy;
      e_busy: if ((pend_q & ~out_hs) == '0) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // Output logic.
  always_comb begin
    ready_and_o = 1'b0;
    busy_o      = 1'b0;
    v_o         = '0;
    unique case (state_q)
      e_idle: ready_and_o = 1'b1;
      e_busy: begin
        busy_o = 1'b1;
        v_o    = pend_q;
      end
      default: ready_and_o = 1'b0;
    endcase
  end

  // Datapath: shares are captured once at accept and held until reissue.
  always_comb begin
    pend_d = pend_q & ~out_hs;
    rot_d  = rot_q;
    data_d = data_q;
    if (accept) begin
      pend_d = nonzero;
      rot_d  = rot_next;
      for (int unsigned i = 0; i < num_out_p; i++) begin
        data_d[i] = {id_in, share[i]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pend_q <= '0;
      rot_q  <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      rot_q  <= rot_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

`ifdef OUTPUTS_WORKLOAD_STATS_EN
  localparam int unsigned sum_w_lp =
    ((size_width_p > stats_width_gp) ? size_width_p : stats_width_gp) + 1;

  logic [num_out_p-1:0][stats_width_gp-1:0] stats_q, stats_d;
  logic [stats_width_gp-1:0]                desc_q, desc_d;
  logic [sum_w_lp-1:0]                      sum;

  always_comb begin
    stats_d = stats_q;
    desc_d  = desc_q;
    sum     = '0;
    if (accept && (desc_q != '1)) begin
      desc_d = desc_q + 1'b1;
    end
    for (int unsigned i = 0; i < num_out_p; i++) begin
      if (out_hs[i]) begin
        sum = sum_w_lp'(stats_q[i]) + sum_w_lp'(data_q[i][size_width_p-1:0]);
        if (sum > sum_w_lp'({stats_width_gp{1'b1}})) begin
          stats_d[i] = '1;
        end else begin
          stats_d[i] = stats_width_gp'(sum);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stats_q <= '0;
      desc_q  <= '0;
    end else begin
      stats_q <= stats_d;
      desc_q  <= desc_d;
    end
  end

  assign stats_o      = stats_q;
  assign desc_count_o = desc_q;
`endif

endmodule

// File: tb/tb_outputs_workload_distribute.sv
// Bench for outputs_workload_distribute with 4 outputs, 8-bit id and size.
// A directed vector table and hand-written sequences run first, then random
// traffic; a cycle reference model checks every cycle throughout.
module tb_outputs_workload_distribute;
  import outputs_workload_pkg::*;

  localparam int unsigned IdW = 8;
  localparam int unsigned SzW = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = IdW + SzW;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                v_i;
  logic [W-1:0]        data_i;
  logic                mode_i;
  logic                ready_and_o;
  logic [N-1:0]        v_o;
  logic [N-1:0][W-1:0] data_o;
  logic [N-1:0]        ready_and_i;
  logic                busy_o;
`ifdef OUTPUTS_WORKLOAD_STATS_EN
  logic [N-1:0][31:0]  stats_o;
  logic [31:0]         desc_count_o;
`endif

  outputs_workload_distribute #(
    .id_width_p         (IdW),
    .size_width_p       (SzW),
    .num_out_p          (N),
    .rotate_remainder_p (1)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .v_i          (v_i),
    .data_i       (data_i),
    .mode_i       (mode_i),
    .ready_and_o  (ready_and_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .ready_and_i  (ready_and_i),
`ifdef OUTPUTS_WORKLOAD_STATS_EN
    .stats_o      (stats_o),
    .desc_count_o (desc_count_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: spec rules with plain integer arithmetic.
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit [N-1:0]  m_pend  = '0;
  int unsigned m_rot   = 0;
  int unsigned m_id    = 0;
  int unsigned m_share [N];
  int unsigned m_size, m_q, m_r, m_pos;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_and_o", 64'(ready_and_o), 64'(!m_busy));
      chk("busy_o", 64'(busy_o), 64'(m_busy));
      chk("v_o", 64'(v_o), m_busy ? 64'(m_pend) : 64'd0);
      for (int i = 0; i < N; i++) begin
        if (m_busy && m_pend[i]) begin
          chk("data_o", 64'(data_o[i]), 64'((m_id << SzW) | m_share[i]));
        end
      end
    end
    // Advance the model with the inputs that the coming rising edge samples.
    if (!reset_n) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_pend  = '0;
      m_rot   = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (v_i) begin
          m_id   = int'(data_i[W-1:SzW]);
          m_size = int'(data_i[SzW-1:0]);
          if (mode_i) begin
            m_q = m_size / N;
            m_r = m_size % N;
            for (int i = 0; i < N; i++) begin
              m_pos      = (i + N - m_rot) % N;
              m_share[i] = m_q + ((m_pos < m_r) ? 1 : 0);
              m_pend[i]  = (m_share[i] != 0);
            end
            m_rot = (m_rot + m_r) % N;
          end else begin
            for (int i = 0; i < N; i++) begin
              m_share[i] = m_size;
              m_pend[i]  = 1'b1;
            end
          end
          m_busy = 1'b1;
        end
      end else begin
        m_pend = m_pend & ~ready_and_i;
        if (m_pend == '0) m_busy = 1'b0;
      end
    end
  end

  // Directed vectors; exp_share is {out3, out2, out1, out0}.
  typedef struct {
    bit                 mode;
    logic [7:0]         id;
    logic [7:0]         size;
    logic [N-1:0]       exp_v;
    logic [N-1:0][7:0]  exp_share;
  } vec_t;

  vec_t vecs [8];
  vec_t post_reset_vec;

  task automatic send_vec(input vec_t t, input string tag);
    v_i         = 1'b1;
    mode_i      = t.mode;
    data_i      = {t.id, t.size};
    ready_and_i = '1;
    chk({tag, "_ready_in"}, 64'(ready_and_o), 64'd1);
    step();
    v_i = 1'b0;
    chk({tag, "_v_o"}, 64'(v_o), 64'(t.exp_v));
    for (int i = 0; i < N; i++) begin
      if (t.exp_v[i]) chk({tag, "_data"}, 64'(data_o[i]), 64'({t.id, t.exp_share[i]}));
    end
    step();
    chk({tag, "_ready_back"}, 64'(ready_and_o), 64'd1);
    chk({tag, "_v_o_idle"}, 64'(v_o), 64'd0);
  endtask

  logic [W-1:0] held;

  initial begin
    vecs[0] = '{1'b1, 8'h11, 8'd10,  4'b1111, {8'd2, 8'd2, 8'd3, 8'd3}};
    vecs[1] = '{1'b1, 8'h22, 8'd10,  4'b1111, {8'd3, 8'd3, 8'd2, 8'd2}};
    vecs[2] = '{1'b0, 8'h33, 8'd7,   4'b1111, {8'd7, 8'd7, 8'd7, 8'd7}};
    vecs[3] = '{1'b1, 8'h44, 8'd0,   4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{1'b1, 8'h55, 8'd2,   4'b0011, {8'd0, 8'd0, 8'd1, 8'd1}};
    vecs[5] = '{1'b1, 8'h66, 8'd5,   4'b1111, {8'd1, 8'd2, 8'd1, 8'd1}};
    vecs[6] = '{1'b1, 8'h77, 8'd3,   4'b1011, {8'd1, 8'd0, 8'd1, 8'd1}};
    vecs[7] = '{1'b1, 8'h88, 8'd255, 4'b1111, {8'd64, 8'd64, 8'd63, 8'd64}};
    post_reset_vec = '{1'b1, 8'hab, 8'd10, 4'b1111, {8'd2, 8'd2, 8'd3, 8'd3}};

    v_i         = 1'b0;
    mode_i      = 1'b0;
    data_i      = '0;
    ready_and_i = '0;
    reset_n     = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    chk("reset_ready", 64'(ready_and_o), 64'd1);
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);

    // Remainder pointer ends at 1 after these.
    foreach (vecs[k]) send_vec(vecs[k], "vec");

    // Staggered readies: output 2 stalls while the others finish.
    ready_and_i = 4'b1011;
    v_i         = 1'b1;
    mode_i      = 1'b0;
    data_i      = {8'h99, 8'd9};
    step();
    v_i = 1'b0;
    chk("stag_v_all", 64'(v_o), 64'hf);
    held = data_o[2];
    step();
    for (int k = 0; k < 3; k++) begin
      chk("stag_v_o", 64'(v_o), 64'b0100);
      chk("stag_ready", 64'(ready_and_o), 64'd0);
      chk("stag_hold", 64'(data_o[2]), 64'(held));
      step();
    end
    ready_and_i = 4'b0100;
    step();
    chk("stag_ready_back", 64'(ready_and_o), 64'd1);
    chk("stag_v_idle", 64'(v_o), 64'd0);

    // Reset while outputs 1 and 3 are still pending.
    ready_and_i = 4'b0101;
    v_i         = 1'b1;
    mode_i      = 1'b0;
    data_i      = {8'h5a, 8'd5};
    step();
    v_i = 1'b0;
    step();
    chk("midrst_pend", 64'(v_o), 64'b1010);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_v_o", 64'(v_o), 64'd0);
    chk("midrst_ready", 64'(ready_and_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
`ifdef OUTPUTS_WORKLOAD_STATS_EN
    chk("midrst_desc_count", 64'(desc_count_o), 64'd0);
`endif
    // Remainder start must be back at output 0.
    send_vec(post_reset_vec, "post_rst");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      reset_n     = ($urandom_range(99) != 0);
      v_i         = $urandom_range(1) != 0;
      mode_i      = $urandom_range(2) != 0;
      data_i[W-1:SzW] = 8'($urandom_range(255));
      data_i[SzW-1:0] = ($urandom_range(3) == 0) ? 8'($urandom_range(255))
                                                 : 8'($urandom_range(9));
      ready_and_i = 4'($urandom_range(15));
      step();
    end
    reset_n = 1'b1;
    v_i     = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
